fc_credit_gated_tx_buffer: RTL and testbench
============================================

# fc_credit_gated_tx_buffer

Transmit-side pending buffer for PCIe flow control. Queues TLPs with their class and data-credit cost, and releases them in order only when the receiver has advertised enough header and data credits for the head entry. Maintains modulo credits-consumed counters for all six credit types. Sits between the transaction-layer TLP source and the data-link-layer transmit path; credit limits come from the DLLP receive logic.

## Interface
- DATA_WIDTH, 160: TLP word stored per entry.
- FIFO_DEPTH, 16: entries; power of two, ≥2.
- HDR_CW, 8: header credit counter/limit width.
- DATA_CW, 12: data credit counter/limit width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  source offers a TLP.
- in_ready  out  1  equals !full.
- in_data  in  DATA_WIDTH  TLP word.
- in_type  in  2  00 posted, 01 non-posted, 10 completion, 11 reserved.
- in_dcred  in  DATA_CW  data credits the TLP consumes; 0 means no payload.
- out_valid  out  1  head entry present and credit check passes.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  head TLP word.
- out_type  out  2  head class.
- hdr_limit  in  3*HDR_CW  header credit limits, packed {CPLH, NPH, PH}.
- data_limit  in  3*DATA_CW  data credit limits, packed {CPLD, NPD, PD}.
- hdr_inf, data_inf  in  3 each  per-class infinite-credit flags, same bit order.
- hdr_consumed  out  3*HDR_CW  header credits consumed.
- data_consumed  out  3*DATA_CW  data credits consumed.
- count  out  $clog2(FIFO_DEPTH+1)  occupancy.
- full, empty  out  1  count==FIFO_DEPTH / count==0.
- blocked  out  1  !empty && !out_valid.
- type_err  out  1  one-cycle pulse on an accepted reserved-type TLP.

## Operation
- Push when in_valid && in_ready: write {data, type, dcred} at wr_ptr; wr_ptr+1 wraps mod FIFO_DEPTH. Reserved type: no write, no count change, type_err=1 next cycle.
- Head fields (out_data, out_type) read combinationally from rd_ptr. Contents are don't-care when empty.
- Gate for head class c, header: hdr_inf[c], or (hdr_limit[c] − (hdr_consumed[c]+1)) mod 2^HDR_CW ≤ 2^(HDR_CW−1).
- Gate for head class c, data: dcred==0, or data_inf[c], or (data_limit[c] − (data_consumed[c]+dcred)) mod 2^DATA_CW ≤ 2^(DATA_CW−1).
- out_valid = !empty && header gate && data gate. Ordering is strict FIFO: a blocked head stalls every entry behind it.
- Pop when out_valid && out_ready: rd_ptr+1 wraps. hdr_consumed[c] += 1 mod 2^HDR_CW. data_consumed[c] += dcred mod 2^DATA_CW.
- Simultaneous push and pop: count unchanged, both pointers advance. Push while full is refused (in_ready=0). There is no same-cycle pass-through.
- Limit changes take effect combinationally on the same cycle's out_valid.

## Timing
- Reset (async assert, sync release): pointers=0, count=0, empty=1, full=0, in_ready=1, out_valid=0, blocked=0, type_err=0, all consumed counters=0. Reset mid-operation discards all entries.
- Push on cycle N: count increments at the edge ending N. The entry can present out_valid in cycle N+1 (one-cycle minimum latency).
- Pop on cycle N: consumed counters update at the same edge. The next head is evaluated against the updated counters in N+1.
- out_valid may deassert without a pop if a limit drops. Downstream must not assume valid is sticky.

## Structure
- Shared package fc_pkg: tlp class enum (FC_P, FC_NP, FC_CPL, FC_RSV), class index constants, default credit-field widths.
- One sub-module fc_credit_gate (parameter CW). Inputs: limit, consumed, required, inf. Output: ok. Instantiate twice, muxed by head class. All storage and counters live in the top.

## Test plan
- Reset, then push posted TLP dcred=4 with hdr_limit PH=1, PD=4 → out_valid in the next cycle. On pop: hdr_consumed PH=1, data_consumed PD=4.
- PD limit=3, push posted dcred=4 → blocked=1, out_valid=0. Raise PD limit to 4 → out_valid=1 the same cycle.
- Wrap-around: PH consumed=255, limit=0 (HDR_CW=8) → gate passes. After pop, consumed=0.
- Fill 16 entries → full=1, in_ready=0. Push and pop together at count=15 → count stays 15.
- Head NP blocked (NPH limit exhausted), posted entry behind it → nothing issues. Set hdr_inf[1]=1 → NP then P issue in order.
- Push in_type=11 → type_err pulse, count unchanged. Assert rst_n low mid-stream → all outputs return to reset values immediately.

Source files
------------

// File: rtl/fc_credit_gated_tx_buffer_pkg.sv
// Shared flow-control definitions: TLP credit classes, class indices and default
// credit counter widths used by the credit-gated transmit buffer.
package fc_pkg;

  typedef enum logic [1:0] {
    FC_P   = 2'b00,
    FC_NP  = 2'b01,
    FC_CPL = 2'b10,
    FC_RSV = 2'b11
  } fc_class_e;

  localparam int FC_IDX_P       = 0;
  localparam int FC_IDX_NP      = 1;
  localparam int FC_IDX_CPL     = 2;
  localparam int FC_NUM_CLASSES = 3;

  localparam int FC_HDR_CW_DEFAULT  = 8;
  localparam int FC_DATA_CW_DEFAULT = 12;

  function automatic logic fc_is_reserved(input logic [1:0] cls);
    return cls == FC_RSV;
  endfunction

endpackage

// File: rtl/fc_credit_gated_tx_buffer_gate.sv
// Modulo credit check: passes when the limit is at or ahead of consumed+required
// within half the counter range, or when the class advertises infinite credit.
module fc_credit_gate #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] limit,
  input  logic [CW-1:0] consumed,
  input  logic [CW-1:0] required,
  input  logic          inf,
  output logic          ok
);

  localparam logic [CW-1:0] HALF_RANGE = {1'b1, {(CW-1){1'b0}}};

  logic [CW-1:0] after_use;
  logic [CW-1:0] headroom;

  assign after_use = consumed + required;
  assign headroom  = limit - after_use;
  assign ok        = inf || (headroom <= HALF_RANGE);

endmodule

// File: rtl/fc_credit_gated_tx_buffer.sv
// In-order TLP pending buffer that releases the head entry only when the receiver
// has advertised enough header and data credits for its class.
module fc_credit_gated_tx_buffer
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = 160,
  parameter int FIFO_DEPTH = 16,
  parameter int HDR_CW     = FC_HDR_CW_DEFAULT,
  parameter int DATA_CW    = FC_DATA_CW_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic [1:0]                      in_type,
  input  logic [DATA_CW-1:0]              in_dcred,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [1:0]                      out_type,
  input  logic [3*HDR_CW-1:0]             hdr_limit,
  input  logic [3*DATA_CW-1:0]            data_limit,
  input  logic [2:0]                      hdr_inf,
  input  logic [2:0]                      data_inf,
  output logic [3*HDR_CW-1:0]             hdr_consumed,
  output logic [3*DATA_CW-1:0]            data_consumed,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            full,
  output logic                            empty,
  output logic                            blocked,
  output logic                            type_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  logic [DATA_WIDTH-1:0] data_mem_q  [FIFO_DEPTH];
  logic [1:0]            type_mem_q  [FIFO_DEPTH];
  logic [DATA_CW-1:0]    dcred_mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [HDR_CW-1:0]  hdr_cons_q  [FC_NUM_CLASSES];
  logic [HDR_CW-1:0]  hdr_cons_d  [FC_NUM_CLASSES];
  logic [DATA_CW-1:0] data_cons_q [FC_NUM_CLASSES];
  logic [DATA_CW-1:0] data_cons_d [FC_NUM_CLASSES];
  logic               type_err_q, type_err_d;

  logic [1:0]         head_type;
  logic [DATA_CW-1:0] head_dcred;
  logic [HDR_CW-1:0]  sel_hdr_limit, sel_hdr_cons;
  logic [DATA_CW-1:0] sel_data_limit, sel_data_cons;
  logic               sel_hdr_inf, sel_data_inf;
  logic               hdr_ok, data_ok;
  logic               push_ok, push_wr, push_rsv, pop;

  assign full     = count_q == CNT_W'(FIFO_DEPTH);
  assign empty    = count_q == '0;
  assign count    = count_q;
  assign in_ready = !full;
  assign type_err = type_err_q;

  assign head_type  = type_mem_q[rd_ptr_q];
  assign head_dcred = dcred_mem_q[rd_ptr_q];
  assign out_data   = data_mem_q[rd_ptr_q];
  assign out_type   = head_type;

  for (genvar g = 0; g < FC_NUM_CLASSES; g++) begin : g_cons_out
    assign hdr_consumed[g*HDR_CW +: HDR_CW]    = hdr_cons_q[g];
    assign data_consumed[g*DATA_CW +: DATA_CW] = data_cons_q[g];
  end

  // Select the credit state of the head entry's class; reserved never reaches storage.
  always_comb begin
    sel_hdr_limit  = '0;
    sel_hdr_cons   = '0;
    sel_hdr_inf    = 1'b0;
    sel_data_limit = '0;
    sel_data_cons  = '0;
    sel_data_inf   = 1'b0;
    for (int c = 0; c < FC_NUM_CLASSES; c++) begin
      if (head_type == 2'(c)) begin
        sel_hdr_limit  = hdr_limit[c*HDR_CW +: HDR_CW];
        sel_hdr_cons   = hdr_cons_q[c];
        sel_hdr_inf    = hdr_inf[c];
        sel_data_limit = data_limit[c*DATA_CW +: DATA_CW];
        sel_data_cons  = data_cons_q[c];
        sel_data_inf   = data_inf[c];
      end
    end
  end

  fc_credit_gate #(.CW(HDR_CW)) u_hdr_gate (
    .limit    (sel_hdr_limit),
    .consumed (sel_hdr_cons),
    .required (HDR_CW'(1)),
    .inf      (sel_hdr_inf),
    .ok       (hdr_ok)
  );

  // A payload-free TLP needs no data credit, so it is treated like infinite data credit.
  fc_credit_gate #(.CW(DATA_CW)) u_data_gate (
    .limit    (sel_data_limit),
    .consumed (sel_data_cons),
    .required (head_dcred),
    .inf      (sel_data_inf || (head_dcred == '0)),
    .ok       (data_ok)
  );

  assign out_valid = !empty && hdr_ok && data_ok;
  assign blocked   = !empty && !out_valid;

  assign push_ok  = in_valid && in_ready;
  assign push_rsv = push_ok && fc_is_reserved(in_type);
  assign push_wr  = push_ok && !fc_is_reserved(in_type);
  assign pop      = out_valid && out_ready;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    hdr_cons_d  = hdr_cons_q;
    data_cons_d = data_cons_q;
    type_err_d  = push_rsv;
    if (push_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_wr, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (pop) begin
      for (int c = 0; c < FC_NUM_CLASSES; c++) begin
        if (head_type == 2'(c)) begin
          hdr_cons_d[c]  = hdr_cons_q[c] + 1'b1;
          data_cons_d[c] = data_cons_q[c] + head_dcred;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      type_err_q  <= 1'b0;
      hdr_cons_q  <= '{default: '0};
      data_cons_q <= '{default: '0};
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      type_err_q  <= type_err_d;
      hdr_cons_q  <= hdr_cons_d;
      data_cons_q <= data_cons_d;
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push_wr) begin
      data_mem_q[wr_ptr_q]  <= in_data;
      type_mem_q[wr_ptr_q]  <= in_type;
      dcred_mem_q[wr_ptr_q] <= in_dcred;
    end
  end

endmodule

// File: tb/tb_fc_credit_gated_tx_buffer.sv
// Directed and randomized bench for the credit-gated transmit buffer, compared
// cycle by cycle against a queue-based credit model.
module tb_fc_credit_gated_tx_buffer;

  localparam int DW    = 160;
  localparam int DEPTH = 16;
  localparam int HCW   = 8;
  localparam int DCW   = 12;
  localparam int HMOD  = 256;
  localparam int DMOD  = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0]   in_data, out_data;
  logic [1:0]      in_type, out_type;
  logic [DCW-1:0]  in_dcred;
  logic [3*HCW-1:0] hdr_limit, hdr_consumed;
  logic [3*DCW-1:0] data_limit, data_consumed;
  logic [2:0]      hdr_inf, data_inf;
  logic [4:0]      count;
  logic            full, empty, blocked, type_err;

  logic [HCW-1:0]  hl [3];
  logic [DCW-1:0]  dl [3];
  assign hdr_limit  = {hl[2], hl[1], hl[0]};
  assign data_limit = {dl[2], dl[1], dl[0]};

  fc_credit_gated_tx_buffer #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .HDR_CW(HCW), .DATA_CW(DCW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_type(in_type), .in_dcred(in_dcred),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_type(out_type),
    .hdr_limit(hdr_limit), .data_limit(data_limit),
    .hdr_inf(hdr_inf), .data_inf(data_inf),
    .hdr_consumed(hdr_consumed), .data_consumed(data_consumed),
    .count(count), .full(full), .empty(empty), .blocked(blocked), .type_err(type_err)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            typ;
    int            dcred;
  } ent_t;

  ent_t q[$];
  int   hc [3];
  int   dc [3];
  bit   terr_m;
  int   total = 0;
  int   bad = 0;

  function automatic int modw(input int v, input int m);
    return ((v % m) + m) % m;
  endfunction

  // The head may issue when its class has a header credit and enough data credit.
  function bit model_valid();
    int c;
    bit hok, dok;
    if (q.size() == 0) return 1'b0;
    c   = q[0].typ;
    hok = hdr_inf[c] || (modw(int'(hl[c]) - hc[c] - 1, HMOD) <= HMOD / 2);
    dok = (q[0].dcred == 0) || data_inf[c] ||
          (modw(int'(dl[c]) - dc[c] - q[0].dcred, DMOD) <= DMOD / 2);
    return hok && dok;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit v, f, e;
    v = model_valid();
    f = (q.size() == DEPTH);
    e = (q.size() == 0);
    chk("out_valid", DW'(out_valid), DW'(v));
    chk("count", DW'(count), DW'(q.size()));
    chk("full", DW'(full), DW'(f));
    chk("empty", DW'(empty), DW'(e));
    chk("in_ready", DW'(in_ready), DW'(!f));
    chk("blocked", DW'(blocked), DW'(!e && !v));
    chk("type_err", DW'(type_err), DW'(terr_m));
    for (int c = 0; c < 3; c++) begin
      chk("hdr_consumed", DW'(hdr_consumed[c*HCW +: HCW]), DW'(hc[c]));
      chk("data_consumed", DW'(data_consumed[c*DCW +: DCW]), DW'(dc[c]));
    end
    if (!e) begin
      chk("out_data", out_data, q[0].data);
      chk("out_type", DW'(out_type), DW'(q[0].typ));
    end
  endtask

  task automatic cycle();
    bit   v, pu, po;
    ent_t e;
    int   c;
    #1;
    check_all();
    v  = model_valid();
    pu = in_valid && (q.size() < DEPTH);
    po = v && out_ready;
    e.data  = in_data;
    e.typ   = int'(in_type);
    e.dcred = int'(in_dcred);
    @(posedge clk);
    #1;
    if (po) begin
      c     = q[0].typ;
      hc[c] = (hc[c] + 1) % HMOD;
      dc[c] = (dc[c] + q[0].dcred) % DMOD;
      void'(q.pop_front());
    end
    terr_m = 1'b0;
    if (pu) begin
      if (e.typ == 3) terr_m = 1'b1;
      else q.push_back(e);
    end
  endtask

  task automatic set_push(input int typ, input int dcred);
    in_valid = 1'b1;
    in_type  = 2'(typ);
    in_dcred = DCW'(dcred);
    in_data  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    for (int c = 0; c < 3; c++) begin
      hc[c] = 0;
      dc[c] = 0;
    end
    terr_m = 1'b0;
    check_all();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_credits();
    for (int c = 0; c < 3; c++) begin
      hl[c] = '0;
      dl[c] = '0;
    end
    hdr_inf  = 3'b000;
    data_inf = 3'b000;
  endtask

  initial begin
    in_valid  = 1'b0;
    in_type   = 2'b00;
    in_dcred  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    clear_credits();
    for (int c = 0; c < 3; c++) begin
      hc[c] = 0;
      dc[c] = 0;
    end
    terr_m = 1'b0;

    // Reset state
    #3;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single posted TLP with exactly enough credit
    hl[0] = 8'd1;
    dl[0] = 12'd4;
    set_push(0, 4);
    cycle();
    in_valid = 1'b0;
    #1;
    chk("t1_valid_next_cycle", DW'(out_valid), DW'(1));
    cycle();
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("t1_ph_consumed", DW'(hdr_consumed[HCW-1:0]), DW'(1));
    chk("t1_pd_consumed", DW'(data_consumed[DCW-1:0]), DW'(4));
    cycle();

    // Data credit short by one, then raised
    do_reset();
    hl[0] = 8'd1;
    dl[0] = 12'd3;
    set_push(0, 4);
    cycle();
    in_valid = 1'b0;
    #1;
    chk("t2_blocked", DW'(blocked), DW'(1));
    chk("t2_not_valid", DW'(out_valid), DW'(0));
    cycle();
    dl[0] = 12'd4;
    #1;
    chk("t2_valid_same_cycle", DW'(out_valid), DW'(1));
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;

    // Header counter wrap-around
    do_reset();
    clear_credits();
    hdr_inf   = 3'b001;
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      set_push(0, 0);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    hdr_inf   = 3'b000;
    hl[0]     = 8'd0;
    #1;
    chk("t3_ph_at_255", DW'(hdr_consumed[HCW-1:0]), DW'(255));
    chk("t3_wrap_gate_passes", DW'(out_valid), DW'(1));
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("t3_ph_wrapped", DW'(hdr_consumed[HCW-1:0]), DW'(0));

    // Fill to full, refuse, then simultaneous push/pop at 15
    do_reset();
    hdr_inf  = 3'b111;
    data_inf = 3'b111;
    for (int i = 0; i < DEPTH; i++) begin
      set_push($urandom_range(0, 2), $urandom_range(0, 30));
      cycle();
    end
    chk("t4_full", DW'(full), DW'(1));
    chk("t4_in_ready_low", DW'(in_ready), DW'(0));
    set_push(0, 1);
    cycle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    set_push(1, 2);
    cycle();
    chk("t4_count_15", DW'(count), DW'(15));
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) cycle();
    out_ready = 1'b0;

    // Blocked non-posted head stalls the posted entry behind it
    do_reset();
    clear_credits();
    hdr_inf = 3'b001;
    set_push(1, 0);
    cycle();
    set_push(0, 0);
    cycle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("t5_stalled_count", DW'(count), DW'(2));
    chk("t5_blocked", DW'(blocked), DW'(1));
    hdr_inf = 3'b011;
    #1;
    chk("t5_np_head", DW'(out_type), DW'(1));
    cycle();
    chk("t5_p_next", DW'(out_type), DW'(0));
    cycle();
    chk("t5_drained", DW'(empty), DW'(1));
    out_ready = 1'b0;

    // Reserved type, then reset with traffic in flight
    set_push(3, 5);
    cycle();
    in_valid = 1'b0;
    chk("t6_type_err_pulse", DW'(type_err), DW'(1));
    chk("t6_count_unchanged", DW'(count), DW'(0));
    cycle();
    chk("t6_type_err_clears", DW'(type_err), DW'(0));
    hdr_inf  = 3'b111;
    data_inf = 3'b111;
    for (int i = 0; i < 3; i++) begin
      set_push(2, 7);
      cycle();
    end
    do_reset();

    // Randomized traffic with moving limits
    clear_credits();
    for (int i = 0; i < 400; i++) begin
      if (i % 8 == 0) begin
        hdr_inf  = ($urandom_range(0, 3) == 0) ? 3'($urandom()) : 3'b000;
        data_inf = ($urandom_range(0, 3) == 0) ? 3'($urandom()) : 3'b000;
        for (int c = 0; c < 3; c++) begin
          hl[c] = HCW'((hc[c] + $urandom_range(0, 4)) % HMOD);
          dl[c] = DCW'((dc[c] + $urandom_range(0, 60)) % DMOD);
        end
      end
      if ($urandom_range(0, 9) < 7) begin
        set_push(($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2),
                 ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 20));
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 9) < 6);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
